// File: rtl/config_axi_writer.sv
// Host-side AXI-lite write initiator: queues whole-layer descriptors and streams each as four
// single-beat writes into config_manager's shadow port, then waits for the epoch flip.
package flexpipe_pkg;
   localparam int unsigned ADDR_WIDTH  = 32;
   localparam int unsigned EPOCH_WIDTH = 2;
endpackage

module config_axi_writer #(
   parameter int unsigned                          FIFO_DEPTH = 4,
   parameter logic [flexpipe_pkg::ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  desc_valid,
   output logic                                  desc_ready,
   input  logic [31:0]                           desc_compute_cycles,
   input  logic [31:0]                           desc_config_bits,
   input  logic [31:0]                           desc_pointer_walks,
   input  logic [31:0]                           desc_data_size,
   output logic [flexpipe_pkg::ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                                  m_axi_awvalid,
   input  logic                                  m_axi_awready,
   output logic [31:0]                           m_axi_wdata,
   output logic [3:0]                            m_axi_wstrb,
   output logic                                  m_axi_wvalid,
   input  logic                                  m_axi_wready,
   input  logic [1:0]                            m_axi_bresp,
   input  logic                                  m_axi_bvalid,
   output logic                                  m_axi_bready,
   input  logic [flexpipe_pkg::EPOCH_WIDTH-1:0]  current_epoch,
   output logic                                  busy,
   output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
   output logic [15:0]                           layers_sent,
   output logic [7:0]                            resp_err_count
);

   localparam int unsigned ADDR_W  = flexpipe_pkg::ADDR_WIDTH;
   localparam int unsigned EPOCH_W = flexpipe_pkg::EPOCH_WIDTH;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_WAIT_FLIP
   } state_e;

   logic [127:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wptr_q;
   logic [PTR_W-1:0]   rptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               push;
   logic               pop;

   state_e             state_q,    state_d;
   logic [1:0]         widx_q,     widx_d;
   logic [127:0]       hold_q,     hold_d;
   logic [ADDR_W-1:0]  awaddr_q,   awaddr_d;
   logic [31:0]        wdata_q,    wdata_d;
   logic [EPOCH_W-1:0] ep_snap_q,  ep_snap_d;
   logic [15:0]        layers_q,   layers_d;
   logic [7:0]         err_q,      err_d;

   // Descriptor FIFO; a full FIFO keeps ready low even if IDLE pops in the same cycle.
   assign desc_ready = (count_q < CNT_W'(FIFO_DEPTH));
   assign push       = desc_valid && desc_ready;
   assign pop        = (state_q == S_IDLE) && (count_q != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= {desc_data_size, desc_pointer_walks, desc_config_bits, desc_compute_cycles};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         widx_q    <= '0;
         hold_q    <= '0;
         awaddr_q  <= BASE_ADDR;
         wdata_q   <= '0;
         ep_snap_q <= '0;
         layers_q  <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         widx_q    <= widx_d;
         hold_q    <= hold_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         ep_snap_q <= ep_snap_d;
         layers_q  <= layers_d;
         err_q     <= err_d;
      end
   end

   // Address and data are loaded on entry to AW/W so the payloads are registered and stable.
   always_comb begin
      state_d   = state_q;
      widx_d    = widx_q;
      hold_d    = hold_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      ep_snap_d = ep_snap_q;
      layers_d  = layers_q;
      err_d     = err_q;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               hold_d   = mem_q[rptr_q];
               widx_d   = '0;
               awaddr_d = BASE_ADDR;
               state_d  = S_AW;
            end
         end
         S_AW: begin
            if (m_axi_awready) begin
               wdata_d = hold_q[{widx_q, 5'b00000} +: 32];
               state_d = S_W;
            end
         end
         S_W: begin
            if (m_axi_wready) begin
               state_d = S_B;
            end
         end
         S_B: begin
            if (m_axi_bvalid) begin
               if ((m_axi_bresp != 2'b00) && (err_q != 8'hFF)) begin
                  err_d = err_q + 8'd1;
               end
               if (widx_q != 2'd3) begin
                  widx_d   = widx_q + 2'd1;
                  awaddr_d = BASE_ADDR + ADDR_W'({widx_q + 2'd1, 2'b00});
                  state_d  = S_AW;
               end else begin
                  ep_snap_d = current_epoch;
                  state_d   = S_WAIT_FLIP;
               end
            end
         end
         S_WAIT_FLIP: begin
            if (current_epoch != ep_snap_q) begin
               layers_d = layers_q + 16'd1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign m_axi_awaddr   = awaddr_q;
   assign m_axi_awvalid  = (state_q == S_AW);
   assign m_axi_wdata    = wdata_q;
   assign m_axi_wstrb    = 4'hF;
   assign m_axi_wvalid   = (state_q == S_W);
   assign m_axi_bready   = (state_q == S_B);
   assign busy           = (state_q != S_IDLE) || (count_q != '0);
   assign fifo_count     = count_q;
   assign layers_sent    = layers_q;
   assign resp_err_count = err_q;

endmodule

// File: tb/tb_config_axi_writer.sv
// Bench for config_axi_writer: scoreboarded AXI-lite responder with stalls, error responses,
// epoch flipping and asynchronous reset mid-burst.
module tb_config_axi_writer;

   localparam int unsigned AW    = flexpipe_pkg::ADDR_WIDTH;
   localparam int unsigned EW    = flexpipe_pkg::EPOCH_WIDTH;
   localparam int unsigned DEPTH = 2;
   localparam logic [AW-1:0] BASE = 'h100;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          desc_valid;
   logic          desc_ready;
   logic [31:0]   desc_cc, desc_cb, desc_pw, desc_ds;
   logic [AW-1:0] awaddr;
   logic          awvalid;
   logic          awready = 1'b0;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready = 1'b0;
   logic [1:0]    bresp = 2'b00;
   logic          bvalid = 1'b0;
   logic          bready;
   logic [EW-1:0] current_epoch = '0;
   logic          busy;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [15:0]   layers_sent;
   logic [7:0]    resp_err_count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_sent;

   exp_t          sb_q[$];
   exp_t          e;
   int            aw_wait = 0, aw_dly = 0, w_wait = 0, w_dly = 0;
   bit            aw_hold = 0, w_hold = 0, b_pending = 0;
   logic [AW-1:0] aw_hold_addr = '0, cur_addr = '0;
   logic [31:0]   w_hold_data = '0;
   int            words_done = 0, flip_cnt = 0, mon_layers = 0, exp_err = 0;
   bit            flip_wait = 0, flip_chk = 0;
   bit            stall_mode, chk_busy;
   int            err_mode;

   config_axi_writer #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .desc_valid          (desc_valid),
      .desc_ready          (desc_ready),
      .desc_compute_cycles (desc_cc),
      .desc_config_bits    (desc_cb),
      .desc_pointer_walks  (desc_pw),
      .desc_data_size      (desc_ds),
      .m_axi_awaddr        (awaddr),
      .m_axi_awvalid       (awvalid),
      .m_axi_awready       (awready),
      .m_axi_wdata         (wdata),
      .m_axi_wstrb         (wstrb),
      .m_axi_wvalid        (wvalid),
      .m_axi_wready        (wready),
      .m_axi_bresp         (bresp),
      .m_axi_bvalid        (bvalid),
      .m_axi_bready        (bready),
      .current_epoch       (current_epoch),
      .busy                (busy),
      .fifo_count          (fifo_count),
      .layers_sent         (layers_sent),
      .resp_err_count      (resp_err_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Responder, scoreboard and epoch flipper all act on the falling edge; the DUT samples at the rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         awready = 0; wready = 0; bvalid = 0; bresp = 2'b00; current_epoch = '0;
         sb_q.delete();
         aw_wait = 0; aw_dly = 0; w_wait = 0; w_dly = 0;
         aw_hold = 0; w_hold = 0; b_pending = 0; words_done = 0;
         flip_wait = 0; flip_chk = 0; flip_cnt = 0; mon_layers = 0; exp_err = 0;
      end else begin
         if (flip_chk) begin
            check_val("layers_after_flip", layers_sent, mon_layers);
            if (chk_busy) check_val("busy_after_flip", busy, 0);
            flip_chk = 0;
         end
         if (flip_wait) begin
            if (flip_cnt == 0) begin
               check_val("flip_hold_awvalid", awvalid, 0);
               check_val("flip_hold_busy", busy, 1);
               check_val("flip_hold_layers", layers_sent, mon_layers);
               current_epoch = current_epoch + 1'b1;
               mon_layers++;
               flip_wait = 0;
               flip_chk  = 1;
            end else begin
               flip_cnt--;
            end
         end
         if (aw_hold) begin
            check_val("aw_stable_valid", awvalid, 1);
            check_val("aw_stable_addr", awaddr, aw_hold_addr);
         end
         if (w_hold) begin
            check_val("w_stable_valid", wvalid, 1);
            check_val("w_stable_data", wdata, w_hold_data);
         end

         awready = 0;
         if (awvalid) begin
            if (aw_wait >= aw_dly) awready = 1;
            else aw_wait++;
         end
         wready = 0;
         if (wvalid) begin
            if (w_wait >= w_dly) wready = 1;
            else w_wait++;
         end
         bvalid = b_pending && bready;
         bresp  = (bvalid && (err_mode == 2 || (err_mode == 1 && words_done == 1))) ? 2'b10 : 2'b00;

         if (desc_valid && desc_ready) begin
            sb_q.push_back('{addr: BASE + AW'(0),  data: desc_cc});
            sb_q.push_back('{addr: BASE + AW'(4),  data: desc_cb});
            sb_q.push_back('{addr: BASE + AW'(8),  data: desc_pw});
            sb_q.push_back('{addr: BASE + AW'(12), data: desc_ds});
         end
         if (awvalid && awready) begin
            check_val("aw_excl_w", wvalid, 0);
            cur_addr = awaddr;
            aw_wait  = 0;
            aw_dly   = stall_mode ? int'($urandom_range(2, 5)) : 0;
         end
         aw_hold      = awvalid && !awready;
         aw_hold_addr = awaddr;
         if (wvalid && wready) begin
            check_val("w_excl_aw", awvalid, 0);
            check_val("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check_val("wr_addr", cur_addr, e.addr);
               check_val("wr_data", wdata, e.data);
               check_val("wr_strb", wstrb, 4'hF);
            end
            b_pending = 1;
            w_wait    = 0;
            w_dly     = stall_mode ? int'($urandom_range(2, 5)) : 0;
         end
         w_hold      = wvalid && !wready;
         w_hold_data = wdata;
         if (bvalid) begin
            b_pending = 0;
            if (bresp != 2'b00 && exp_err < 255) exp_err++;
            words_done++;
            if (words_done == 4) begin
               words_done = 0;
               flip_wait  = 1;
               flip_cnt   = 5;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_desc(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
      int t = 0;
      desc_valid = 1; desc_cc = a; desc_cb = b; desc_pw = c; desc_ds = d;
      while (!desc_ready && t < 500) begin
         tick();
         t++;
      end
      check_val("desc_accept_in_time", t < 500, 1);
      tick();
      desc_valid = 0;
      n_sent++;
   endtask

   task automatic send_rand();
      send_desc($urandom, $urandom, $urandom, $urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || flip_wait || flip_chk) && t < 3000) begin
         tick();
         t++;
      end
      check_val("idle_in_time", t < 3000, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_awvalid"}, awvalid, 0);
      check_val({tag, "_wvalid"}, wvalid, 0);
      check_val({tag, "_bready"}, bready, 0);
      check_val({tag, "_awaddr"}, awaddr, BASE);
      check_val({tag, "_wdata"}, wdata, 0);
      check_val({tag, "_wstrb"}, wstrb, 4'hF);
      check_val({tag, "_desc_ready"}, desc_ready, 1);
      check_val({tag, "_fifo_count"}, fifo_count, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_layers"}, layers_sent, 0);
      check_val({tag, "_errs"}, resp_err_count, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst_n = 0; desc_valid = 0; desc_cc = '0; desc_cb = '0; desc_pw = '0; desc_ds = '0;
      stall_mode = 0; err_mode = 0; chk_busy = 0; n_sent = 0;
      tick(3);
      check_reset_vals("por");
      rst_n = 1;
      tick(2);

      // single descriptor, exact first-beat latency
      chk_busy = 1;
      send_desc(32'd10, 32'hA5, 32'd3, 32'd64);
      check_val("aw_latency_pre", awvalid, 0);
      tick();
      check_val("aw_latency_post", awvalid, 1);
      check_val("aw_first_addr", awaddr, BASE);
      wait_idle();
      chk_busy = 0;
      check_val("single_layers", layers_sent, 16'(n_sent));

      // back-to-back into a depth-2 FIFO
      send_rand();
      send_rand();
      send_rand();
      check_val("full_ready", desc_ready, 0);
      check_val("full_count", fifo_count, 2);
      wait_idle();
      check_val("b2b_layers", layers_sent, 16'(n_sent));

      // responder stalls
      stall_mode = 1;
      send_rand();
      send_rand();
      wait_idle();
      stall_mode = 0;
      check_val("stall_layers", layers_sent, 16'(n_sent));

      // error responses and saturation
      err_mode = 1;
      send_rand();
      wait_idle();
      check_val("err_one", resp_err_count, 1);
      err_mode = 2;
      repeat (75) send_rand();
      wait_idle();
      err_mode = 0;
      check_val("err_saturated", resp_err_count, 255);
      check_val("err_layers", layers_sent, 16'(n_sent));

      // epoch wrap from all-ones to zero
      t = 0;
      while (current_epoch != '1 && t < 8) begin
         send_rand();
         wait_idle();
         t++;
      end
      send_rand();
      wait_idle();
      check_val("wrap_layers", layers_sent, 16'(n_sent));

      // asynchronous reset during W of word 2 with another descriptor queued
      send_rand();
      send_rand();
      t = 0;
      while (!(wvalid && words_done == 2) && t < 200) begin
         tick();
         t++;
      end
      check_val("reach_w2_in_time", t < 200, 1);
      rst_n = 0;
      #1;
      check_reset_vals("async_rst");
      tick(2);
      rst_n = 1;
      n_sent = 0;
      tick();
      send_desc(32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000);
      tick();
      check_val("post_rst_awvalid", awvalid, 1);
      check_val("post_rst_awaddr", awaddr, BASE);
      wait_idle();
      check_val("post_rst_layers", layers_sent, 16'(n_sent));
      check_val("post_rst_errs", resp_err_count, 0);
      check_val("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/config_axi_writer.md
# config_axi_writer

Host-side AXI-lite write initiator feeding `config_manager`'s shadow config port. Buffers whole-layer descriptors in a small FIFO and serialises each into four sequential single-beat AXI-lite writes (compute_cycles, config_bits, pointer_walks, data_size). After the fourth write it holds off the next descriptor until `current_epoch` advances, so the shadow register is never overwritten before the flip.

## Interface
- FIFO_DEPTH, 4: descriptor FIFO entries; power of two, ≥2.
- BASE_ADDR, 0: address of word 0; word k is driven at BASE_ADDR + 4*k.
- ADDR_WIDTH, EPOCH_WIDTH: taken from `flexpipe_pkg`, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  FIFO not full.
- desc_compute_cycles, desc_config_bits, desc_pointer_walks, desc_data_size  in  32 each  descriptor words 0..3.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awvalid  out  1; m_axi_awready  in  1.
- m_axi_wdata  out  32; m_axi_wstrb  out  4  always 4'hF.
- m_axi_wvalid  out  1; m_axi_wready  in  1.
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
- current_epoch  in  EPOCH_WIDTH  epoch from config_manager.
- busy  out  1  FSM not in IDLE or FIFO non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- layers_sent  out  16  descriptors completed (flip observed), wraps.
- resp_err_count  out  8  B responses with bresp≠0, saturates at 255.

## Operation
- FIFO: push on desc_valid && desc_ready; pop when FSM leaves IDLE. Push and pop in the same cycle keeps count. desc_ready = count < FIFO_DEPTH (a full FIFO with a same-cycle pop does not assert ready).
- FSM states: IDLE, AW, W, B, WAIT_FLIP. Word index `widx` is 2 bits.
- IDLE: if FIFO non-empty, pop the head into the 128-bit holding register, widx←0, go to AW.
- AW: awvalid=1, awaddr=BASE_ADDR+4*widx. On awvalid&&awready go to W.
- W: wvalid=1, wdata=hold[widx]. On wvalid&&wready go to B.
- B: bready=1. On bvalid, if bresp≠0 increment resp_err_count (saturating). The write is not retried. If widx<3, widx++ and go to AW. If widx==3, latch current_epoch into ep_snap and go to WAIT_FLIP.
- WAIT_FLIP: when current_epoch≠ep_snap (any change, including wrap), increment layers_sent and go to IDLE.
- AW and W are never asserted together. Only one transaction is outstanding at a time, matching the responder's sequential IDLE→WRITE→RESP flow.
- Once asserted, awvalid/wvalid and their payloads stay stable until the handshake completes.

## Timing
- All outputs are registered or decoded from registered state.
- Reset values: awvalid=wvalid=bready=0, awaddr=BASE_ADDR, wdata=0, wstrb=4'hF, FSM=IDLE, widx=0, FIFO empty, desc_ready=1, fifo_count=0, busy=0, layers_sent=0, resp_err_count=0, ep_snap=0.
- Desc handshake at edge N → IDLE pops at edge N+1 → awvalid high in the cycle after edge N+1.
- With a zero-wait responder, each word takes 3 states (AW, W, B). Minimum four-word burst is 12 cycles plus WAIT_FLIP.
- The responder's word counter has no clear input; both blocks share rst_n. Reset mid-burst returns everything to reset values, discards the FIFO contents, and drops the in-flight beat.
- An epoch change during AW/W/B is ignored; only WAIT_FLIP compares against ep_snap.

## Test plan
- Single descriptor {10, 0xA5, 3, 64}, zero-wait responder, flip 5 cycles after the 4th B: addresses BASE+0/4/8/C and data 10/0xA5/3/64 in order; WAIT_FLIP holds until epoch 0→1; layers_sent=1; busy drops the cycle after.
- Three descriptors back-to-back with FIFO_DEPTH=2: desc_ready falls while 2 entries are held. No AW for descriptor 2 until epoch increments for descriptor 1. All 12 writes occur in order.
- Responder holds awready and wready low for 4 random cycles each: valid signals and payloads stay stable; no overlap of AW and W.
- bresp=2'b10 on word 1: resp_err_count=1; words 2–3 are still issued. Force 300 errors: counter saturates at 255.
- Epoch wrap with EPOCH_WIDTH=2: current_epoch 3→0 releases WAIT_FLIP; layers_sent increments.
- Assert rst_n low during W of word 2 with 1 descriptor queued: all outputs go to reset values asynchronously. After release a new descriptor is written from word 0 at BASE+0.
